manhattan_dist_collector: RTL and testbench
===========================================

Name: manhattan_dist_collector

Overview:
Upstream stage of the 8-way minimum selector. Latches a query point, accepts 8 candidate points serially over a valid/ready stream, and computes each Manhattan distance |qx-px|+|qy-py|. Holds all 8 distances in a register bank, presented on d_0..d_7 straight into the min selector's inputs. Raises dist_valid until the consumer acknowledges.

Parameters:
COORD_W, 9, width of each unsigned coordinate
D_W, 10, distance width; fixed at COORD_W+1 (max 2*(2^COORD_W-1) fits exactly)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latches q_x/q_y and begins a frame (honoured only in IDLE)
q_x  input  COORD_W  query x
q_y  input  COORD_W  query y
pt_valid  input  1  candidate point valid
pt_ready  output  1  collector can accept a point
pt_x  input  COORD_W  candidate x
pt_y  input  COORD_W  candidate y
busy  output  1  high in LOAD (and while the pipeline drains)
dist_valid  output  1  d_0..d_7 complete and stable
dist_ack  input  1  consumer has taken the results
d_0..d_7  output  D_W each  distance of candidate 0..7, in arrival order

Behaviour:
- Reset (async assert, sync release): state=IDLE, count=0, d_0..d_7=0, q regs=0, pt_ready=0, busy=0, dist_valid=0.
- FSM states: IDLE, LOAD, DRAIN (used only with the optional feature), DONE.
- IDLE: pt_ready=0. start=1 -> latch q_x/q_y, count=0, go LOAD.
- LOAD: pt_ready=1, busy=1. A transfer occurs on pt_valid&&pt_ready. On each transfer, dist = |q_x-pt_x| + |q_y-pt_y|, with each difference taken as larger minus smaller (no signed wrap). The sum is D_W bits and never overflows. dist is written to d_[count], then count increments.
- The 8th transfer (count==7) goes to DONE next cycle; count wraps to 0.
- pt_valid=0 cycles stall without effect; there is no timeout.
- DONE: dist_valid=1, pt_ready=0, busy=0, d_0..d_7 held stable. dist_ack=1 -> IDLE next cycle, dist_valid drops. d_* keep their values until overwritten by the next frame.
- start is ignored outside IDLE. start and dist_ack in the same cycle while in DONE: the ack wins, go to IDLE; that start is lost.
- dist_ack outside DONE is ignored.
- Registers not yet written in a new frame still show the prior frame's values. Consumers qualify d_* only with dist_valid.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- Latency: dist_valid rises 1 cycle after the 8th accepted transfer. Minimum frame is 1 (start) + 8 + 1 = 10 cycles.

Optional Feature:
MAN_DIST_PIPE_EN. When defined:
- The abs-difference pair and its index are registered, and the sum and write-back happen one cycle later. This breaks the subtract/add path.
- After the 8th transfer the FSM enters DRAIN for 1 cycle (busy=1, pt_ready=0), then DONE. dist_valid therefore rises 2 cycles after the 8th transfer.
- Reset clears the pipeline registers.

When undefined: no DRAIN state, single-cycle compute-and-write as described above. Results are identical in both builds; only timing differs.

Test Plan:
- Reset then idle: hold rst_n=0 5 cycles, release -> all d_*=0, dist_valid=0, pt_ready=0, busy=0.
- Basic frame: query (100,200); points (100,200), (0,0), (511,511), (511,0), (0,511), (150,150), (99,201), (300,100) back-to-back -> d_0..d_7 = 0, 300, 722, 611, 411, 100, 2, 300. dist_valid rises 1 cycle (2 with MAN_DIST_PIPE_EN) after the last transfer.
- Extremes: query (0,0), all points (511,511) -> every d_*=1022, no overflow. Query (511,511), point (0,0) -> 1022.
- Stalls and ack hold: pt_valid toggled 1/0, plus dist_ack withheld 20 cycles -> 8 transfers land in order, dist_valid and d_* stay constant until ack, then IDLE.
- Ignored controls: start pulses during LOAD and DONE, plus dist_ack during LOAD -> no restart, count unaffected. Simultaneous start+ack in DONE -> IDLE, no new frame.
- Async reset mid-frame: assert rst_n=0 off-edge after 4 transfers -> outputs clear immediately. A fresh frame afterwards completes correctly.

Source files
------------

// File: rtl/manhattan_dist_collector_if.sv
// Point-stream and result bus between the Manhattan distance collector and its neighbours.
// master = producer/consumer side, slave = the collector itself.
interface manhattan_dist_collector_if #(
  parameter int COORD_W = 9
);
  localparam int D_W = COORD_W + 1;

  logic               start;
  logic [COORD_W-1:0] q_x;
  logic [COORD_W-1:0] q_y;
  logic               pt_valid;
  logic               pt_ready;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;
  logic               busy;
  logic               dist_valid;
  logic               dist_ack;
  logic [D_W-1:0]     d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7;

  modport master (
    output start, q_x, q_y, pt_valid, pt_x, pt_y, dist_ack,
    input  pt_ready, busy, dist_valid,
    input  d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7
  );

  modport slave (
    input  start, q_x, q_y, pt_valid, pt_x, pt_y, dist_ack,
    output pt_ready, busy, dist_valid,
    output d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7
  );
endinterface

// File: rtl/manhattan_dist_collector.sv
// Latches a query point, takes 8 candidates serially and holds their Manhattan distances.
// Define MAN_DIST_PIPE_EN to register the abs-differences before the add (adds a DRAIN cycle).
module manhattan_dist_collector #(
  parameter int COORD_W = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  manhattan_dist_collector_if.slave     bus
);
  localparam int D_W = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         count_reg, count_next;
  logic [COORD_W-1:0] qx_reg, qy_reg;

  logic               xfer;
  logic [COORD_W-1:0] dx, dy;
  logic               wr_en;
  logic [2:0]         wr_idx;
  logic [D_W-1:0]     wr_dist;

  assign xfer = (state_reg == LOAD) && bus.pt_valid;

  // Larger minus smaller keeps each difference unsigned with no wrap.
  assign dx = (qx_reg >= bus.pt_x) ? (qx_reg - bus.pt_x) : (bus.pt_x - qx_reg);
  assign dy = (qy_reg >= bus.pt_y) ? (qy_reg - bus.pt_y) : (bus.pt_y - qy_reg);

`ifdef MAN_DIST_PIPE_EN
  logic               p_valid_reg;
  logic [2:0]         p_idx_reg;
  logic [COORD_W-1:0] p_dx_reg, p_dy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_reg <= 1'b0;
      p_idx_reg   <= '0;
      p_dx_reg    <= '0;
      p_dy_reg    <= '0;
    end else begin
      p_valid_reg <= xfer;
      if (xfer) begin
        p_idx_reg <= count_reg;
        p_dx_reg  <= dx;
        p_dy_reg  <= dy;
      end
    end
  end

  assign wr_en   = p_valid_reg;
  assign wr_idx  = p_idx_reg;
  assign wr_dist = {1'b0, p_dx_reg} + {1'b0, p_dy_reg};
`else
  assign wr_en   = xfer;
  assign wr_idx  = count_reg;
  assign wr_dist = {1'b0, dx} + {1'b0, dy};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qx_reg <= '0;
      qy_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      qx_reg <= bus.q_x;
      qy_reg <= bus.q_y;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    bus.pt_ready   = 1'b0;
    bus.busy       = 1'b0;
    bus.dist_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      LOAD: begin
        bus.pt_ready = 1'b1;
        bus.busy     = 1'b1;
        if (xfer) begin
          count_next = count_reg + 3'd1;
          if (count_reg == 3'd7) begin
`ifdef MAN_DIST_PIPE_EN
            state_next = DRAIN;
`else
            state_next = DONE;
`endif
          end
        end
      end
      DRAIN: begin
        // Last candidate is still in the pipeline register; let it land.
        bus.busy   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        bus.dist_valid = 1'b1;
        if (bus.dist_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bank
      logic [D_W-1:0] d_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_reg <= '0;
        else if (wr_en && wr_idx == 3'(gi)) d_reg <= wr_dist;
      end
    end
  endgenerate

  assign bus.d_0 = g_bank[0].d_reg;
  assign bus.d_1 = g_bank[1].d_reg;
  assign bus.d_2 = g_bank[2].d_reg;
  assign bus.d_3 = g_bank[3].d_reg;
  assign bus.d_4 = g_bank[4].d_reg;
  assign bus.d_5 = g_bank[5].d_reg;
  assign bus.d_6 = g_bank[6].d_reg;
  assign bus.d_7 = g_bank[7].d_reg;
endmodule

// File: tb/tb_manhattan_dist_collector.sv
// Scoreboard bench: stimulus pushes expected 8-distance frames, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_manhattan_dist_collector;
`ifdef MAN_DIST_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  manhattan_dist_collector_if #(.COORD_W(9)) bus ();
  manhattan_dist_collector #(.COORD_W(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [79:0] exp_q[$];
  logic [79:0] cur = '0;
  logic [79:0] act;
  logic prev_dv = 1'b0;
  int frame_no = 0;

  assign act = {bus.d_7, bus.d_6, bus.d_5, bus.d_4, bus.d_3, bus.d_2, bus.d_1, bus.d_0};

  task automatic check(input string name, input int actual, input int req);
    total++;
    if (actual != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, actual, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [79:0] actual, input logic [79:0] req);
    total++;
    if (actual !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, actual, req);
    end
  endtask

  task automatic push8(input int v0, v1, v2, v3, v4, v5, v6, v7);
    logic [79:0] f;
    f = {10'(v7), 10'(v6), 10'(v5), 10'(v4), 10'(v3), 10'(v2), 10'(v1), 10'(v0)};
    exp_q.push_back(f);
  endtask

  // Monitor: pops one expected frame per dist_valid rise, then checks it stays put.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv = 1'b0;
    end else begin
      if (bus.dist_valid && !prev_dv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dist_valid", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          for (int i = 0; i < 8; i++)
            check($sformatf("frame%0d_d_%0d", frame_no, i), int'(act[i*10 +: 10]), int'(cur[i*10 +: 10]));
          $display("frame %0d: d = %0d %0d %0d %0d %0d %0d %0d %0d", frame_no,
                   bus.d_0, bus.d_1, bus.d_2, bus.d_3, bus.d_4, bus.d_5, bus.d_6, bus.d_7);
          frame_no++;
        end
      end else if (bus.dist_valid) begin
        check_vec("d_hold", act, cur);
      end
      prev_dv = bus.dist_valid;
    end
  end

  task automatic start_frame(input int x, input int y);
    bus.q_x = 9'(x);
    bus.q_y = 9'(y);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.q_x = '0;
    bus.q_y = '0;
  endtask

  task automatic send_pt(input int x, input int y);
    int n = 0;
    bus.pt_valid = 1'b1;
    bus.pt_x = 9'(x);
    bus.pt_y = 9'(y);
    while (!bus.pt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pt_ready) check("pt_ready_timeout", 0, 1);
    @(negedge clk);
    bus.pt_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.dist_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("dist_valid_latency", n + 1, LAT);
  endtask

  task automatic ack_frame(input int hold);
    repeat (hold) @(negedge clk);
    check("dist_valid_before_ack", int'(bus.dist_valid), 1);
    bus.dist_ack = 1'b1;
    @(negedge clk);
    bus.dist_ack = 1'b0;
    check("dist_valid_after_ack", int'(bus.dist_valid), 0);
    check("pt_ready_after_ack", int'(bus.pt_ready), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.q_x = '0;
    bus.q_y = '0;
    bus.pt_valid = 1'b0;
    bus.pt_x = '0;
    bus.pt_y = '0;
    bus.dist_ack = 1'b0;

    // Reset then idle
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("reset_d", act, 80'h0);
    check("reset_dist_valid", int'(bus.dist_valid), 0);
    check("reset_pt_ready", int'(bus.pt_ready), 0);
    check("reset_busy", int'(bus.busy), 0);

    // Basic frame
    push8(0, 300, 722, 611, 411, 100, 2, 300);
    start_frame(100, 200);
    check("load_pt_ready", int'(bus.pt_ready), 1);
    check("load_busy", int'(bus.busy), 1);
    send_pt(100, 200); send_pt(0, 0);   send_pt(511, 511); send_pt(511, 0);
    send_pt(0, 511);   send_pt(150, 150); send_pt(99, 201); send_pt(300, 100);
    wait_valid();
    check("done_busy", int'(bus.busy), 0);
    check("done_pt_ready", int'(bus.pt_ready), 0);
    ack_frame(0);

    // Extremes
    push8(1022, 1022, 1022, 1022, 1022, 1022, 1022, 1022);
    start_frame(0, 0);
    for (int i = 0; i < 8; i++) send_pt(511, 511);
    wait_valid();
    ack_frame(1);

    push8(1022, 0, 511, 511, 510, 1022, 2, 1020);
    start_frame(511, 511);
    send_pt(0, 0);     send_pt(511, 511); send_pt(0, 511);   send_pt(511, 0);
    send_pt(256, 256); send_pt(0, 0);     send_pt(510, 510); send_pt(1, 1);
    wait_valid();
    ack_frame(0);

    // Stalls and ack withheld 20 cycles
    push8(30, 0, 20, 10, 521, 501, 480, 1);
    start_frame(10, 20);
    send_pt(0, 0);     @(negedge clk); send_pt(10, 20);  @(negedge clk);
    send_pt(20, 10);   @(negedge clk); send_pt(5, 25);   @(negedge clk);
    send_pt(511, 0);   @(negedge clk); send_pt(0, 511);  @(negedge clk);
    send_pt(255, 255); @(negedge clk); send_pt(10, 21);
    wait_valid();
    ack_frame(20);

    // Ignored controls: start + ack during LOAD, start during DONE, start+ack in DONE
    push8(0, 20, 110, 90, 2, 2, 390, 912);
    start_frame(50, 60);
    send_pt(50, 60); send_pt(60, 50); send_pt(0, 0);
    bus.start = 1'b1;
    bus.dist_ack = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dist_ack = 1'b0;
    check("load_ignores_start_ack", int'(bus.pt_ready), 1);
    send_pt(100, 100); send_pt(51, 61); send_pt(49, 59); send_pt(200, 300); send_pt(511, 511);
    wait_valid();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_ignores_start_dv", int'(bus.dist_valid), 1);
    check("done_ignores_start_rdy", int'(bus.pt_ready), 0);
    bus.start = 1'b1;
    bus.dist_ack = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dist_ack = 1'b0;
    check("start_ack_dv", int'(bus.dist_valid), 0);
    check("start_ack_rdy", int'(bus.pt_ready), 0);
    @(negedge clk);
    check("start_ack_stays_idle", int'(bus.pt_ready), 0);

    // Async reset mid-frame
    start_frame(7, 7);
    send_pt(1, 1); send_pt(2, 2); send_pt(3, 3); send_pt(4, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_vec("async_reset_d", act, 80'h0);
    check("async_reset_pt_ready", int'(bus.pt_ready), 0);
    check("async_reset_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_dist_valid", int'(bus.dist_valid), 0);

    // Fresh frame after reset
    push8(4, 3, 0, 13, 2, 1019, 509, 510);
    start_frame(1, 2);
    send_pt(3, 4); send_pt(0, 0);     send_pt(1, 2);   send_pt(8, 8);
    send_pt(2, 1); send_pt(511, 511); send_pt(1, 511); send_pt(511, 2);
    wait_valid();
    ack_frame(2);

    repeat (3) @(negedge clk);
    check("frames_left_in_queue", exp_q.size(), 0);
    check("frames_seen", frame_no, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
